// File: rtl/pipe_pkg.sv
// Shared constants and types for the fetch / IF-ID pipeline slice.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, IF/ID register, stall/redirect handling and perf counters.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_Write,
  input  logic             IF_Write,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ID_instruction,
  output logic [31:0]      ID_pc_plus4,
  output logic             ID_valid,
  output logic [4:0]       IF_Rs,
  output logic [4:0]       IF_Rt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0] pc_q, pc_plus4, redirect_pc;
  logic        redirect_acc;
  ifid_t       ifid_q;

  assign pc_plus4     = pc_q + PC_INC;
  assign redirect_pc  = redirect_target & ~32'h3;
  // A redirect seen while the PC is held is dropped; ID re-asserts it after the stall.
  assign redirect_acc = redirect_valid & PC_Write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc_q <= RESET_PC;
    else if (PC_Write) pc_q <= redirect_acc ? redirect_pc : pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ifid_q <= IFID_BUBBLE;
    else if (IF_Write) begin
      if (redirect_acc)    ifid_q <= IFID_BUBBLE;
      else                 ifid_q <= '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~IF_Write),
    .count(stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (redirect_acc),
    .count(flush_count)
  );

  assign imem_addr      = pc_q;
  assign ID_instruction = ifid_q.instr;
  assign ID_pc_plus4    = ifid_q.pc_plus4;
  assign ID_valid       = ifid_q.valid;
  assign IF_Rs          = ifid_q.instr[RS_MSB:RS_LSB];
  assign IF_Rt          = ifid_q.instr[RT_MSB:RT_LSB];

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-side stage that consumes the stall handshake from the hazard detection unit (`PC_Write`, `IF_Write`) and the redirect from the ID-stage branch/jump logic. It owns the PC register and the IF/ID pipeline register. It drives the instruction-memory address and returns the IF/ID-held source-register fields (`IF_Rs`, `IF_Rt`) to the hazard unit, closing the loop. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; low 2 bits must be 0.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `PC_Write`  in  1: 1 = PC may update; 0 = hold PC (from hazard unit).
- `IF_Write`  in  1: 1 = IF/ID may update; 0 = hold IF/ID (from hazard unit).
- `redirect_valid`  in  1: taken branch or jump resolved in ID this cycle.
- `redirect_target`  in  32: redirect PC; bits [1:0] ignored (forced 0).
- `imem_addr`  out  32: current PC, to combinational instruction memory.
- `imem_rdata`  in  32: instruction at `imem_addr`, same cycle.
- `ID_instruction`  out  32: IF/ID instruction.
- `ID_pc_plus4`  out  32: IF/ID PC+4.
- `ID_valid`  out  1: IF/ID holds a real instruction (0 = bubble).
- `IF_Rs`  out  5: `ID_instruction[25:21]`.
- `IF_Rt`  out  5: `ID_instruction[20:16]`.
- `stall_count`  out  `CNT_W`: cycles with `IF_Write`=0, saturating.
- `flush_count`  out  `CNT_W`: accepted redirects, saturating.

## Operation
- State consists of the PC register, the IF/ID register (instr, pc_plus4, valid), and two counters.
- A redirect is accepted when `redirect_valid`=1 and `PC_Write`=1.
- If `PC_Write`=0, `redirect_valid` is ignored. The ID stage holds the branch and re-asserts the redirect once the stall clears.
- PC next-value priority: `rst` first, then hold (`PC_Write`=0), then accepted redirect loads `{redirect_target[31:2],2'b00}`, otherwise PC+4.
- PC+4 is a modulo-2^32 add: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID next-value priority: `rst` first, then hold (`IF_Write`=0), then flush on accepted redirect, otherwise load.
  - Flush: instr=32'h0000_0000 (NOP), pc_plus4=0, valid=0.
  - Load: instr=`imem_rdata`, pc_plus4=PC+4, valid=1.
- `PC_Write` and `IF_Write` are applied independently. If `PC_Write`=1 and `IF_Write`=0, the PC advances and the fetched word is dropped. The hazard unit never drives this combination, but the stage still defines the behaviour.
- `stall_count` increments on each cycle with `IF_Write`=0 and sticks at all-ones.
- `flush_count` increments on each accepted redirect and sticks at all-ones.
- `IF_Rs` and `IF_Rt` are combinational slices of the IF/ID register. A bubble yields 0/0, which never matches a hazard because $0 is excluded.

## Timing
- Reset values (asynchronous, effective immediately): PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `ID_instruction`=0, `ID_pc_plus4`=0, `ID_valid`=0, `IF_Rs`=0, `IF_Rt`=0, both counters 0.
- Deassertion of reset: the first rising edge afterwards loads IF/ID from `RESET_PC`.
- Fetch latency is 1 cycle: the word at `imem_addr` in cycle N appears on `ID_instruction` in cycle N+1.
- Stall signals arrive already registered from the hazard unit. A stall asserted for k cycles holds both registers for exactly k edges, with no lost or duplicated instruction.
- A redirect accepted at edge N places `redirect_target` on `imem_addr` after N, plus exactly one bubble in IF/ID. The branch penalty is 1 cycle.
- `redirect_valid` together with `PC_Write`=0: no state change except `stall_count` (when `IF_Write`=0).
- `rst` asserted mid-stall or mid-redirect overrides everything asynchronously.

## Structure
- Shared package `pipe_pkg` holds:
  - `NOP_INSTR` (32'h0);
  - `RS_MSB`/`RS_LSB` (25/21) and `RT_MSB`/`RT_LSB` (20/16);
  - `PC_INC` (4).
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst`, `inc`, `count`) is instantiated twice.

## Test plan
- Reset release, no stalls, imem returns addr-based words: `imem_addr` = 0, 4, 8 on consecutive cycles. `ID_instruction` lags by 1 cycle. `ID_valid` becomes 1 after the first edge.
- Load-use stall: `PC_Write`=`IF_Write`=0 for 1 cycle while IF/ID holds the word from addr 8. PC stays 12 and IF/ID stays the addr-8 word for 1 extra cycle, then the stream resumes at 16. `stall_count`=1.
- Redirect with `redirect_target`=32'h0000_0042 at PC=20: next `imem_addr`=32'h40, one bubble (`ID_valid`=0, `IF_Rs`=`IF_Rt`=0), then the addr-40 word. `flush_count`=1.
- `redirect_valid`=1 with `PC_Write`=0 for 2 cycles, then `PC_Write`=1: the redirect takes effect only on the third edge. `flush_count`=1 and `stall_count`=2.
- Wrap and saturation: PC forced to 32'hFFFF_FFFC then advances to 0. With `CNT_W`=4, a 20-cycle stall leaves `stall_count`=15.
- Async reset mid-stall: all outputs return to their reset values immediately, before the next clock edge.
